// File: rtl/axi_burst_addr_gen.sv
// rtl/axi_burst_addr_gen.sv - expands one AXI AW/AR request into per-beat addresses
module axi_burst_addr_gen #(
    parameter int C_AXI_ID_WIDTH   = 6,
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_LEN_WIDTH  = 8
) (
    input  logic                        S_AXI_ACLK,
    input  logic                        S_AXI_ARESETN,
    input  logic                        S_AXI_AXVALID,
    output logic                        S_AXI_AXREADY,
    input  logic [C_AXI_ID_WIDTH-1:0]   S_AXI_AXID,
    input  logic [C_AXI_ADDR_WIDTH-1:0] S_AXI_AXADDR,
    input  logic [C_AXI_LEN_WIDTH-1:0]  S_AXI_AXLEN,
    input  logic [2:0]                  S_AXI_AXSIZE,
    input  logic [1:0]                  S_AXI_AXBURST,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [C_AXI_ID_WIDTH-1:0]   o_id,
    output logic [C_AXI_ADDR_WIDTH-1:0] o_addr,
    output logic [C_AXI_LEN_WIDTH-1:0]  o_beat,
    output logic                        o_last,
    output logic                        o_err
);

    localparam int AW = C_AXI_ADDR_WIDTH;
    localparam int LW = C_AXI_LEN_WIDTH;
    localparam int IW = C_AXI_ID_WIDTH;
    localparam logic [2:0] MAX_SIZE = 3'($clog2(C_AXI_DATA_WIDTH / 8));

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    logic [0:0]    state_q, state_d;
    logic [IW-1:0] id_q, id_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] beat_q, beat_d;
    logic [LW-1:0] len_q, len_d;
    logic          last_q, last_d;
    logic          err_q, err_d;
    logic [2:0]    size_q, size_d;
    logic [1:0]    burst_q, burst_d;
    logic [AW-1:0] wrap_low_q, wrap_low_d;
    logic [AW-1:0] wrap_end_q, wrap_end_d;

    logic          accept;
    logic          beat_hs;
    logic [2:0]    size_c;
    logic [AW-1:0] step_c;
    logic [AW-1:0] len_ext;
    logic [AW-1:0] last_addr_c;
    logic [AW-1:0] wrap_bytes_c;
    logic [AW-1:0] wrap_low_c;
    logic          wrap_len_ok;
    logic          err_c;
    logic [AW-1:0] step_q;
    logic [AW-1:0] incr_next;
    logic [AW-1:0] next_addr;

    assign o_valid       = (state_q == ST_BURST);
    assign S_AXI_AXREADY = S_AXI_ARESETN && (!o_valid || (last_q && i_ready));
    assign accept        = S_AXI_AXVALID && S_AXI_AXREADY;
    assign beat_hs       = o_valid && i_ready;

    // Request decode: oversize beats are clamped to the bus width for address math.
    assign size_c       = (S_AXI_AXSIZE > MAX_SIZE) ? MAX_SIZE : S_AXI_AXSIZE;
    assign step_c       = AW'(1) << size_c;
    assign len_ext      = AW'(S_AXI_AXLEN);
    assign last_addr_c  = (S_AXI_AXADDR & ~(step_c - AW'(1))) + (len_ext << size_c);
    assign wrap_bytes_c = (len_ext + AW'(1)) << size_c;
    assign wrap_low_c   = S_AXI_AXADDR & ~(wrap_bytes_c - AW'(1));
    assign wrap_len_ok  = (S_AXI_AXLEN == LW'(1)) || (S_AXI_AXLEN == LW'(3)) ||
                          (S_AXI_AXLEN == LW'(7)) || (S_AXI_AXLEN == LW'(15));

    assign err_c = (S_AXI_AXBURST == BURST_RSVD) ||
                   (S_AXI_AXSIZE > MAX_SIZE) ||
                   ((S_AXI_AXBURST == BURST_WRAP) && !wrap_len_ok) ||
                   ((S_AXI_AXBURST == BURST_WRAP) && ((S_AXI_AXADDR & (step_c - AW'(1))) != '0)) ||
                   ((S_AXI_AXBURST == BURST_INCR) && (last_addr_c[AW-1:12] != S_AXI_AXADDR[AW-1:12])) ||
                   ((S_AXI_AXBURST == BURST_FIXED) && (S_AXI_AXLEN > LW'(15)));

    assign step_q    = AW'(1) << size_q;
    assign incr_next = (addr_q & ~(step_q - AW'(1))) + step_q;

    always_comb begin
        next_addr = incr_next;
        case (burst_q)
            BURST_FIXED: next_addr = addr_q;
            BURST_WRAP:  next_addr = (incr_next == wrap_end_q) ? wrap_low_q : incr_next;
            default:     next_addr = incr_next;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        addr_d     = addr_q;
        beat_d     = beat_q;
        len_d      = len_q;
        last_d     = last_q;
        err_d      = err_q;
        size_d     = size_q;
        burst_d    = burst_q;
        wrap_low_d = wrap_low_q;
        wrap_end_d = wrap_end_q;
        if (accept) begin
            state_d    = ST_BURST;
            id_d       = S_AXI_AXID;
            addr_d     = S_AXI_AXADDR;
            beat_d     = '0;
            len_d      = S_AXI_AXLEN;
            last_d     = (S_AXI_AXLEN == '0);
            err_d      = err_c;
            size_d     = size_c;
            burst_d    = S_AXI_AXBURST;
            wrap_low_d = wrap_low_c;
            wrap_end_d = wrap_low_c + wrap_bytes_c;
        end else if (beat_hs) begin
            if (last_q) begin
                state_d = ST_IDLE;
                last_d  = 1'b0;
            end else begin
                beat_d = beat_q + LW'(1);
                last_d = ((beat_q + LW'(1)) == len_q);
                addr_d = next_addr;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state_q    <= ST_IDLE;
            id_q       <= '0;
            addr_q     <= '0;
            beat_q     <= '0;
            len_q      <= '0;
            last_q     <= 1'b0;
            err_q      <= 1'b0;
            size_q     <= '0;
            burst_q    <= '0;
            wrap_low_q <= '0;
            wrap_end_q <= '0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            addr_q     <= addr_d;
            beat_q     <= beat_d;
            len_q      <= len_d;
            last_q     <= last_d;
            err_q      <= err_d;
            size_q     <= size_d;
            burst_q    <= burst_d;
            wrap_low_q <= wrap_low_d;
            wrap_end_q <= wrap_end_d;
        end
    end

    assign o_id   = id_q;
    assign o_addr = addr_q;
    assign o_beat = beat_q;
    assign o_last = last_q;
    assign o_err  = err_q;

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// tb/tb_axi_burst_addr_gen.sv - directed self-checking bench for axi_burst_addr_gen
module tb_axi_burst_addr_gen;

    logic        clk = 1'b0;
    logic        resetn;
    logic        axvalid;
    logic        axready;
    logic [5:0]  axid;
    logic [31:0] axaddr;
    logic [7:0]  axlen;
    logic [2:0]  axsize;
    logic [1:0]  axburst;
    logic        o_valid;
    logic        i_ready;
    logic [5:0]  o_id;
    logic [31:0] o_addr;
    logic [7:0]  o_beat;
    logic        o_last;
    logic        o_err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_addr [16];

    always #5 clk = ~clk;

    axi_burst_addr_gen dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (resetn),
        .S_AXI_AXVALID (axvalid),
        .S_AXI_AXREADY (axready),
        .S_AXI_AXID    (axid),
        .S_AXI_AXADDR  (axaddr),
        .S_AXI_AXLEN   (axlen),
        .S_AXI_AXSIZE  (axsize),
        .S_AXI_AXBURST (axburst),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_id          (o_id),
        .o_addr        (o_addr),
        .o_beat        (o_beat),
        .o_last        (o_last),
        .o_err         (o_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic exp4(input logic [31:0] a0, a1, a2, a3);
        exp_addr[0] = a0;
        exp_addr[1] = a1;
        exp_addr[2] = a2;
        exp_addr[3] = a3;
    endtask

    task automatic drive_req(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
        axvalid = 1'b1;
        axid    = id;
        axaddr  = addr;
        axlen   = len;
        axsize  = size;
        axburst = burst;
    endtask

    // Presents a request to an idle DUT; returns at the negedge where beat 0 is visible.
    task automatic issue(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        @(negedge clk);
        drive_req(id, addr, len, size, burst);
        #1;
        check("axready_idle", axready, 1'b1);
        @(negedge clk);
        axvalid = 1'b0;
    endtask

    task automatic collect(input int n, input logic exp_err, input logic [5:0] exp_id, input bit rnd);
        logic [63:0] snap;
        bit stalled;
        int got;
        int cyc;
        snap = '0;
        stalled = 1'b0;
        got = 0;
        cyc = 0;
        while (got < n && cyc < 100) begin
            i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            check("valid", o_valid, 1'b1);
            if (stalled) check("stable", {o_addr, o_id, o_beat, o_last, o_err}, snap);
            snap = {o_addr, o_id, o_beat, o_last, o_err};
            check("addr", o_addr, exp_addr[got]);
            check("beat", o_beat, got);
            check("last", o_last, (got == n - 1));
            check("err", o_err, exp_err);
            check("id", o_id, exp_id);
            stalled = !i_ready;
            if (i_ready) got++;
            cyc++;
            @(negedge clk);
        end
        if (got < n) check("timeout", got, n);
        i_ready = 1'b1;
    endtask

    task automatic run(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst, input logic exp_err, input bit rnd);
        issue(id, addr, len, size, burst);
        collect(int'(len) + 1, exp_err, id, rnd);
        #1;
        check("idle_after", o_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn  = 1'b0;
        axvalid = 1'b0;
        axid    = '0;
        axaddr  = '0;
        axlen   = '0;
        axsize  = '0;
        axburst = '0;
        i_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", o_valid, 1'b0);
        check("rst_last", o_last, 1'b0);
        check("rst_err", o_err, 1'b0);
        check("rst_beat", o_beat, 8'd0);
        check("rst_addr", o_addr, 32'd0);
        check("rst_id", o_id, 6'd0);
        check("rst_axready", axready, 1'b0);
        resetn = 1'b1;
        #1;
        check("rel_axready", axready, 1'b1);

        exp4(32'h1000, 32'h1004, 32'h1008, 32'h100C);
        run(6'd1, 32'h1000, 8'd3, 3'd2, 2'b01, 1'b0, 1'b0);
        exp4(32'h1003, 32'h1004, 32'h1008, 32'h0);
        run(6'd2, 32'h1003, 8'd2, 3'd2, 2'b01, 1'b0, 1'b0);
        exp4(32'h100C, 32'h1000, 32'h1004, 32'h1008);
        run(6'd3, 32'h100C, 8'd3, 3'd2, 2'b10, 1'b0, 1'b0);
        exp4(32'h2000, 32'h2000, 32'h2000, 32'h0);
        run(6'd4, 32'h2000, 8'd2, 3'd2, 2'b00, 1'b0, 1'b0);

        exp4(32'h1000, 32'h1004, 32'h1008, 32'h100C);
        exp_addr[4] = 32'h1010;
        exp_addr[5] = 32'h1014;
        exp_addr[6] = 32'h1018;
        exp_addr[7] = 32'h101C;
        run(6'd5, 32'h1000, 8'd7, 3'd2, 2'b01, 1'b0, 1'b1);

        exp4(32'h1000, 32'h1004, 32'h1008, 32'h0);
        run(6'd6, 32'h1000, 8'd2, 3'd2, 2'b10, 1'b1, 1'b0);
        exp4(32'h2000, 32'h2004, 32'h0, 32'h0);
        run(6'd7, 32'h2000, 8'd1, 3'd3, 2'b01, 1'b1, 1'b0);
        exp4(32'h0FFC, 32'h1000, 32'h0, 32'h0);
        run(6'd8, 32'h0FFC, 8'd1, 3'd2, 2'b01, 1'b1, 1'b0);
        exp4(32'h5000, 32'h5004, 32'h5008, 32'h0);
        run(6'd9, 32'h5000, 8'd2, 3'd2, 2'b11, 1'b1, 1'b0);

        // Back-to-back: second request waits for the last-beat handshake.
        issue(6'd10, 32'h3000, 8'd1, 3'd2, 2'b01);
        drive_req(6'd11, 32'h4000, 8'd0, 3'd2, 2'b00);
        i_ready = 1'b1;
        #1;
        check("b2b_axready_busy", axready, 1'b0);
        check("b2b_beat0", o_addr, 32'h3000);
        @(negedge clk);
        #1;
        check("b2b_beat1", o_addr, 32'h3004);
        check("b2b_last", o_last, 1'b1);
        check("b2b_axready_last", axready, 1'b1);
        @(negedge clk);
        axvalid = 1'b0;
        #1;
        check("b2b_valid2", o_valid, 1'b1);
        check("b2b_addr2", o_addr, 32'h4000);
        check("b2b_id2", o_id, 6'd11);
        check("b2b_beatidx2", o_beat, 8'd0);
        check("b2b_last2", o_last, 1'b1);
        @(negedge clk);
        #1;
        check("b2b_idle", o_valid, 1'b0);

        // Reset while beat 2 of an 8-beat burst is presented.
        issue(6'd12, 32'h1000, 8'd7, 3'd2, 2'b01);
        i_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("mid_beat2", o_beat, 8'd2);
        check("mid_addr2", o_addr, 32'h1008);
        resetn = 1'b0;
        @(negedge clk);
        #1;
        check("mid_rst_valid", o_valid, 1'b0);
        check("mid_rst_addr", o_addr, 32'd0);
        check("mid_rst_beat", o_beat, 8'd0);
        check("mid_rst_axready", axready, 1'b0);
        resetn = 1'b1;
        #1;
        check("mid_rel_axready", axready, 1'b1);
        exp4(32'h6000, 32'h6004, 32'h0, 32'h0);
        run(6'd13, 32'h6000, 8'd1, 3'd2, 2'b01, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
